// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe register pipeline.
//   dff_pipe_cfg_t       default WIDTH / DEPTH / RESET_VAL bundle
//   clog2_count(depth)   width needed to hold a count in 0..depth
//   DFF_FLUSH_ACTIVE     asserted level of the synchronous flush input
package dff_pkg;

  typedef struct packed {
    int unsigned width;
    int unsigned depth;
    logic [63:0] reset_val;
  } dff_pipe_cfg_t;

  localparam dff_pipe_cfg_t DFF_PIPE_CFG_DEFAULT = '{
    width:     32'd8,
    depth:     32'd3,
    reset_val: 64'd0
  };

  localparam logic DFF_FLUSH_ACTIVE = 1'b1;

  // Bits needed to represent every value 0..depth inclusive.
  function automatic int unsigned clog2_count(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid flag plus a data register.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous clear
//   load       capture load_data this cycle (sets v)
//   load_data  word to capture
//   adv        stage contents move downstream this cycle (clears v unless reloaded)
//   v, d       registered valid flag and data word
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int unsigned       WIDTH     = DFF_PIPE_CFG_DEFAULT.width,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             adv,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (flush == DFF_FLUSH_ACTIVE) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (load) begin
      v <= 1'b1;
      d <= load_data;
    end else if (adv) begin
      // Data is left stale; only the valid flag drops.
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Fixed-latency, back-pressurable delay line of DEPTH register stages with a
// valid/ready handshake on both ends and bubble collapsing.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous clear, blocks transfers in the cycle it is high
//   in_valid / in_ready / in_data     producer side
//   out_valid / out_ready / out_data  consumer side (out_data straight from the last flop)
//   count      number of occupied stages, 0..DEPTH
module dff_pipe
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_PIPE_CFG_DEFAULT.width,
  parameter int unsigned      DEPTH     = DFF_PIPE_CFG_DEFAULT.depth,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_PIPE_CFG_DEFAULT.reset_val),
  parameter int unsigned      CW        = clog2_count(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             flush_act;

  assign flush_act = (flush == DFF_FLUSH_ACTIVE);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             ld;
    logic [WIDTH-1:0] ld_data;

    // Closed form of adv[i] = v[i] & (!v[i+1] | adv[i+1]): a stage moves if any
    // stage above it is empty (that hole absorbs the shift) or the output pops.
    if (i == DEPTH - 1) begin : g_tail
      assign adv[i] = v[i] & out_ready;
    end else begin : g_inner
      assign adv[i] = v[i] & (~(&v[DEPTH-1:i+1]) | out_ready);
    end

    if (i == 0) begin : g_head
      assign ld      = in_valid & in_ready;
      assign ld_data = in_data;
    end else begin : g_body
      assign ld      = adv[i-1];
      assign ld_data = d[i-1];
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (ld),
      .load_data (ld_data),
      .adv       (adv[i]),
      .v         (v[i]),
      .d         (d[i])
    );
  end

  // reset is part of in_ready so nothing is accepted while held in reset.
  assign in_ready  = (~v[0] | adv[0]) & reset & ~flush_act;
  assign out_valid = v[DEPTH-1] & ~flush_act;
  assign out_data  = d[DEPTH-1];
  assign count     = CW'($countones(v));

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic       chk_d;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  logic       clk;
  logic       reset;

  logic       m_flush, m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [7:0] m_in_data, m_out_data;
  logic [1:0] m_count;

  logic       s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0] s_in_data, s_out_data;
  logic [0:0] s_count;

  int tests;
  int fails;

  dff_pipe #(
    .WIDTH     (8),
    .DEPTH     (3),
    .RESET_VAL (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (m_flush),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .in_data   (m_in_data),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .out_data  (m_out_data),
    .count     (m_count)
  );

  dff_pipe #(
    .WIDTH (8),
    .DEPTH (1)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .count     (s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s #%0d: got %0h, required %0h", nm, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [7:0] din, logic ordy, logic fl, logic ir,
                              logic ov, logic cd, logic [7:0] od, logic [1:0] cnt);
    vec_t t;
    t.iv = iv; t.din = din; t.ordy = ordy; t.fl = fl;
    t.e_ir = ir; t.e_ov = ov; t.chk_d = cd; t.e_od = od; t.e_cnt = cnt;
    return t;
  endfunction

  // Drive one vector at the falling edge, check pre-edge outputs 1 ns later.
  task automatic run_vec(input bit one, input vec_t t, input int idx);
    @(negedge clk);
    if (one) begin
      s_in_valid = t.iv; s_in_data = t.din; s_out_ready = t.ordy; s_flush = t.fl;
    end else begin
      m_in_valid = t.iv; m_in_data = t.din; m_out_ready = t.ordy; m_flush = t.fl;
    end
    #1;
    if (one) begin
      chk("d1_in_ready", idx, 32'(s_in_ready), 32'(t.e_ir));
      chk("d1_out_valid", idx, 32'(s_out_valid), 32'(t.e_ov));
      chk("d1_count", idx, 32'(s_count), 32'(t.e_cnt));
      if (t.chk_d) chk("d1_out_data", idx, 32'(s_out_data), 32'(t.e_od));
    end else begin
      chk("in_ready", idx, 32'(m_in_ready), 32'(t.e_ir));
      chk("out_valid", idx, 32'(m_out_valid), 32'(t.e_ov));
      chk("count", idx, 32'(m_count), 32'(t.e_cnt));
      if (t.chk_d) chk("out_data", idx, 32'(m_out_data), 32'(t.e_od));
    end
  endtask

  vec_t mq[$];
  vec_t sq[$];

  initial begin
    int lat;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    m_flush = 0; m_in_valid = 1; m_in_data = 8'h00; m_out_ready = 0;
    s_flush = 0; s_in_valid = 0; s_in_data = 8'h00; s_out_ready = 0;

    //            iv  din    ordy fl  ir  ov  chk od     cnt
    // stream
    mq.push_back(mk(1, 8'h11, 1, 0, 1, 0, 1, 8'hFF, 0));
    mq.push_back(mk(1, 8'h22, 1, 0, 1, 0, 0, 8'h00, 1));
    mq.push_back(mk(1, 8'h33, 1, 0, 1, 0, 0, 8'h00, 2));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'h11, 3));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'h22, 2));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'h33, 1));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0));
    // backpressure
    mq.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 0, 8'h00, 0));
    mq.push_back(mk(1, 8'hA2, 0, 0, 1, 0, 0, 8'h00, 1));
    mq.push_back(mk(1, 8'hA3, 0, 0, 1, 0, 0, 8'h00, 2));
    mq.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 1, 8'hA1, 3));
    mq.push_back(mk(1, 8'hA4, 1, 0, 1, 1, 1, 8'hA1, 3));
    mq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'hA2, 3));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'hA2, 3));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'hA3, 2));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'hA4, 1));
    mq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
    // bubble collapse
    mq.push_back(mk(1, 8'h05, 0, 0, 1, 0, 0, 8'h00, 0));
    mq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
    mq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
    mq.push_back(mk(1, 8'h06, 0, 0, 1, 1, 1, 8'h05, 1));
    mq.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 8'h05, 2));
    mq.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 8'h05, 2));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'h05, 2));
    mq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'h06, 1));
    mq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
    // flush with two words held
    mq.push_back(mk(1, 8'hB1, 0, 0, 1, 0, 0, 8'h00, 0));
    mq.push_back(mk(1, 8'hB2, 0, 0, 1, 0, 0, 8'h00, 1));
    mq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 2));
    mq.push_back(mk(1, 8'hB3, 1, 1, 0, 0, 1, 8'hB1, 2));
    mq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 8'hFF, 0));
    // fill for the async reset sequence
    mq.push_back(mk(1, 8'hC1, 0, 0, 1, 0, 1, 8'hFF, 0));
    mq.push_back(mk(1, 8'hC2, 0, 0, 1, 0, 1, 8'hFF, 1));
    mq.push_back(mk(1, 8'hC3, 0, 0, 1, 0, 1, 8'hFF, 2));

    // DEPTH=1: pass-through while full, stall without out_ready
    sq.push_back(mk(1, 8'hD0, 1, 0, 1, 0, 1, 8'h00, 0));
    sq.push_back(mk(1, 8'hD1, 1, 0, 1, 1, 1, 8'hD0, 1));
    sq.push_back(mk(1, 8'hD2, 1, 0, 1, 1, 1, 8'hD1, 1));
    sq.push_back(mk(1, 8'hE0, 0, 0, 0, 1, 1, 8'hD2, 1));
    sq.push_back(mk(1, 8'hE0, 1, 0, 1, 1, 1, 8'hD2, 1));
    sq.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 8'hE0, 1));
    sq.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0));

    // Values while held in reset
    @(negedge clk);
    #1;
    chk("rst_in_ready", 0, 32'(m_in_ready), 32'd0);
    chk("rst_out_valid", 0, 32'(m_out_valid), 32'd0);
    chk("rst_out_data", 0, 32'(m_out_data), 32'hFF);
    chk("rst_count", 0, 32'(m_count), 32'd0);
    @(negedge clk);
    m_in_valid = 0;
    reset = 1'b1;

    foreach (mq[i]) run_vec(1'b0, mq[i], i);

    // Full pipeline, then drop reset between edges.
    @(negedge clk);
    m_in_valid = 0;
    #1;
    chk("full_count", 0, 32'(m_count), 32'd3);
    chk("full_out_data", 0, 32'(m_out_data), 32'hC1);
    #2;
    reset = 1'b0;
    m_in_valid = 1;
    m_in_data = 8'hC7;
    #1;
    chk("arst_out_valid", 0, 32'(m_out_valid), 32'd0);
    chk("arst_count", 0, 32'(m_count), 32'd0);
    chk("arst_out_data", 0, 32'(m_out_data), 32'hFF);
    chk("arst_in_ready", 0, 32'(m_in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("arst_hold_in_ready", 0, 32'(m_in_ready), 32'd0);
    reset = 1'b1;
    m_out_ready = 1;
    #1;
    chk("arst_release_in_ready", 0, 32'(m_in_ready), 32'd1);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      m_in_valid = 0;
      #1;
      lat++;
      if (m_out_valid) break;
    end
    chk("arst_latency", 0, 32'(lat), 32'd3);
    chk("arst_latency_data", 0, 32'(m_out_data), 32'hC7);

    foreach (sq[i]) run_vec(1'b1, sq[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
